// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M/RV64M multiply/divide unit for the EX stage.
//
// Multiplies use shift-add on a 2*XLEN accumulator, divides use restoring
// division; both retire UNROLL bits per clock over N = XLEN/UNROLL cycles.
// Divides by zero and the signed MIN_INT / -1 overflow skip iteration and
// finish one cycle after acceptance.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   start   request pulse, accepted only while busy is low
//   kill    pipeline flush: abandon the in-flight operation, no done
//   funct3  RV M-extension operation select
//   a, b    rs1 / rs2 operands, latched at acceptance
//   result  registered result, written only in the finishing cycle
//   busy    operation in flight (new starts ignored)
//   done    one-cycle pulse, result valid

// Elaboration-time parameter legality check.
module muldiv_unit_cfg_check #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) ();
  if (!((XLEN == 32) || (XLEN == 64))) begin : gBadXlen
    $error("muldiv_unit: XLEN must be 32 or 64");
  end
  if (!((UNROLL == 1) || (UNROLL == 2) || (UNROLL == 4))) begin : gBadUnroll
    $error("muldiv_unit: UNROLL must be 1, 2 or 4");
  end
  if ((XLEN % UNROLL) != 0) begin : gBadRatio
    $error("muldiv_unit: XLEN must be a multiple of UNROLL");
  end
endmodule

module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  localparam logic [CW-1:0]   ONE      = CW'(1);
  localparam logic [CW-1:0]   ITERS    = CW'(N);
  localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_X   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_unit_cfg_check #(.XLEN(XLEN), .UNROLL(UNROLL)) cfgCheck ();

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [2:0]        op;
  logic [2*XLEN-1:0] acc;        // {partial hi, multiplier} or {remainder, dividend/quotient}
  logic [XLEN-1:0]   operand;    // multiplicand magnitude or divisor magnitude
  logic              negMain;    // product / quotient must be negated
  logic              negRem;     // remainder must be negated
  logic              special;    // result precomputed at acceptance
  logic [XLEN-1:0]   specialVal;

  logic              aSigned;
  logic              bSigned;
  logic              aNeg;
  logic              bNeg;
  logic [XLEN-1:0]   aMag;
  logic [XLEN-1:0]   bMag;
  logic              bZero;
  logic              divOverflow;
  logic              takeSpecial;
  logic [XLEN-1:0]   specialRes;

  // Operand signedness, magnitudes and RISC-V special-case divide results.
  always_comb begin
    aSigned = 1'b0;
    bSigned = 1'b0;
    case (funct3)
      3'b001:  begin aSigned = 1'b1; bSigned = 1'b1; end  // MULH
      3'b010:  begin aSigned = 1'b1; bSigned = 1'b0; end  // MULHSU
      3'b100:  begin aSigned = 1'b1; bSigned = 1'b1; end  // DIV
      3'b110:  begin aSigned = 1'b1; bSigned = 1'b1; end  // REM
      default: begin aSigned = 1'b0; bSigned = 1'b0; end
    endcase
    aNeg = aSigned & a[XLEN-1];
    bNeg = bSigned & b[XLEN-1];
    // -MIN_INT wraps to MIN_INT, which is the correct unsigned magnitude.
    aMag = aNeg ? -a : a;
    bMag = bNeg ? -b : b;
    bZero       = (b == ZERO_X);
    divOverflow = funct3[2] & ~funct3[0] & (a == MIN_INT) & (b == ONES_X);
    takeSpecial = funct3[2] & (bZero | divOverflow);
    if (bZero) begin
      specialRes = funct3[1] ? a : ONES_X;
    end else begin
      specialRes = funct3[1] ? ZERO_X : MIN_INT;
    end
  end

  logic [2*XLEN-1:0] accNext;
  logic [XLEN:0]     stepVal;

  // One clock's worth of UNROLL shift-add or restoring-divide steps.
  always_comb begin
    accNext = acc;
    stepVal = {(XLEN+1){1'b0}};
    for (int i = 0; i < UNROLL; i++) begin
      if (op[2]) begin
        // Partial remainder shifted left with the next dividend bit appended.
        stepVal = accNext[2*XLEN-1:XLEN-1];
        if (stepVal >= {1'b0, operand}) begin
          stepVal = stepVal - {1'b0, operand};
          accNext = {stepVal[XLEN-1:0], accNext[XLEN-2:0], 1'b1};
        end else begin
          accNext = {stepVal[XLEN-1:0], accNext[XLEN-2:0], 1'b0};
        end
      end else begin
        // Carry out of the add becomes the new top bit after the right shift.
        stepVal = {1'b0, accNext[2*XLEN-1:XLEN]}
                + (accNext[0] ? {1'b0, operand} : {(XLEN+1){1'b0}});
        accNext = {stepVal, accNext[XLEN-1:1]};
      end
    end
  end

  logic [2*XLEN-1:0] prodFixed;
  logic [XLEN-1:0]   quotFixed;
  logic [XLEN-1:0]   remFixed;
  logic [XLEN-1:0]   finRes;

  // Sign correction and output selection for the finishing cycle.
  always_comb begin
    prodFixed = negMain ? -acc : acc;
    quotFixed = negMain ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remFixed  = negRem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (special) begin
      finRes = specialVal;
    end else begin
      case (op)
        3'b000:  finRes = prodFixed[XLEN-1:0];
        3'b001:  finRes = prodFixed[2*XLEN-1:XLEN];
        3'b010:  finRes = prodFixed[2*XLEN-1:XLEN];
        3'b011:  finRes = prodFixed[2*XLEN-1:XLEN];
        3'b100:  finRes = quotFixed;
        3'b101:  finRes = quotFixed;
        default: finRes = remFixed;
      endcase
    end
  end

  // Control FSM, operand capture, iteration and result register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= {CW{1'b0}};
      op         <= 3'b000;
      acc        <= {(2*XLEN){1'b0}};
      operand    <= ZERO_X;
      negMain    <= 1'b0;
      negRem     <= 1'b0;
      special    <= 1'b0;
      specialVal <= ZERO_X;
      result     <= ZERO_X;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        // Flush wins over everything, including a start or the FIN write.
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op         <= funct3;
              negMain    <= aNeg ^ bNeg;
              negRem     <= aNeg;
              special    <= takeSpecial;
              specialVal <= specialRes;
              count      <= ITERS;
              busy       <= 1'b1;
              if (funct3[2]) begin
                acc     <= {ZERO_X, aMag};
                operand <= bMag;
              end else begin
                acc     <= {ZERO_X, bMag};
                operand <= aMag;
              end
              state <= takeSpecial ? FIN : CALC;
            end
          end
          CALC: begin
            acc   <= accNext;
            count <= count - ONE;
            if (count == ONE) begin
              state <= FIN;
            end
          end
          FIN: begin
            result <= finRes;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: three instances (XLEN/UNROLL =
// 32/1, 32/4, 64/2) share one stimulus bus selected by 'sel'.
module tb_muldiv_unit;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  typedef struct {
    int          inst;
    logic [2:0]  f;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        startReq;
  logic        killReq;
  int          sel;
  logic [2:0]  fIn;
  logic [63:0] aIn;
  logic [63:0] bIn;
  logic [31:0] res0;
  logic [31:0] res1;
  logic [63:0] res2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [63:0] obsRes;
  logic        obsBusy;
  logic        obsDone;
  int          nChecks = 0;
  int          nFails  = 0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .UNROLL(1)) u0 (
    .clk(clk), .reset(reset), .start(startReq && (sel == 0)), .kill(killReq && (sel == 0)),
    .funct3(fIn), .a(aIn[31:0]), .b(bIn[31:0]), .result(res0), .busy(busy0), .done(done0));

  muldiv_unit #(.XLEN(32), .UNROLL(4)) u1 (
    .clk(clk), .reset(reset), .start(startReq && (sel == 1)), .kill(killReq && (sel == 1)),
    .funct3(fIn), .a(aIn[31:0]), .b(bIn[31:0]), .result(res1), .busy(busy1), .done(done1));

  muldiv_unit #(.XLEN(64), .UNROLL(2)) u2 (
    .clk(clk), .reset(reset), .start(startReq && (sel == 2)), .kill(killReq && (sel == 2)),
    .funct3(fIn), .a(aIn), .b(bIn), .result(res2), .busy(busy2), .done(done2));

  always_comb begin
    case (sel)
      1:       begin obsRes = {32'd0, res1}; obsBusy = busy1; obsDone = done1; end
      2:       begin obsRes = res2;          obsBusy = busy2; obsDone = done2; end
      default: begin obsRes = {32'd0, res0}; obsBusy = busy0; obsDone = done0; end
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input int inst, input logic [2:0] f, input logic [63:0] x,
                              input logic [63:0] y, input logic [63:0] exp, input int lat,
                              input string name);
    vec_t v;
    v.inst = inst; v.f = f; v.x = x; v.y = y; v.exp = exp; v.lat = lat; v.name = name;
    vecs.push_back(v);
  endfunction

  // Drive a start for exactly one edge, then scramble the inputs.
  task automatic pulseStart(input int inst, input logic [2:0] f, input logic [63:0] x,
                            input logic [63:0] y);
    sel = inst; fIn = f; aIn = x; bIn = y; startReq = 1'b1;
    @(posedge clk); #1;
    startReq = 1'b0; fIn = ~f; aIn = ~x; bIn = ~y;
  endtask

  // Called just after the accepting edge; lat = edges until done, -1 on timeout.
  task automatic waitDone(output int lat, output int busyCnt, output logic busyAtDone);
    lat = -1;
    busyCnt = obsBusy ? 1 : 0;
    busyAtDone = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (obsDone) begin
        lat = k;
        busyAtDone = obsBusy;
        break;
      end
      if (obsBusy) busyCnt++;
    end
  endtask

  task automatic runVec(input vec_t v);
    int   lat;
    int   bc;
    logic bd;
    pulseStart(v.inst, v.f, v.x, v.y);
    waitDone(lat, bc, bd);
    check({v.name, " result"}, obsRes, v.exp);
    check({v.name, " latency"}, 64'(lat), 64'(v.lat));
    check({v.name, " busy cycles"}, 64'(bc), 64'(v.lat));
    check({v.name, " busy at done"}, {63'd0, bd}, 64'd0);
    @(posedge clk); #1;
    check({v.name, " done width"}, {63'd0, obsDone}, 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   bc;
    logic bd;
    int   doneSeen;

    reset = 1'b1; startReq = 1'b0; killReq = 1'b0; sel = 0;
    fIn = 3'b000; aIn = 64'd0; bIn = 64'd0;

    add(0, MUL,    64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, 33, "MUL 7*-3");
    add(0, MUL,    64'h12345678, 64'h10,       64'h23456780, 33, "MUL shift");
    add(0, MULH,   64'h80000000, 64'h80000000, 64'h40000000, 33, "MULH min*min");
    add(0, MULH,   64'hFFFFFFFD, 64'h5,        64'hFFFFFFFF, 33, "MULH -3*5");
    add(0, MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33, "MULHU max*max");
    add(0, MULHSU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 33, "MULHSU -1*max");
    add(0, DIV,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 33, "DIV -7/2");
    add(0, REM,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 33, "REM -7/2");
    add(0, DIV,    64'h7,        64'hFFFFFFFE, 64'hFFFFFFFD, 33, "DIV 7/-2");
    add(0, REM,    64'h7,        64'hFFFFFFFE, 64'h1,        33, "REM 7/-2");
    add(0, DIVU,   64'd100,      64'd7,        64'd14,       33, "DIVU 100/7");
    add(0, REMU,   64'd100,      64'd7,        64'd2,        33, "REMU 100/7");
    add(0, DIVU,   64'h80000000, 64'hFFFFFFFF, 64'h0,        33, "DIVU min/max");
    add(0, DIVU,   64'd5,        64'd0,        64'hFFFFFFFF, 1,  "DIVU 5/0");
    add(0, REM,    64'd5,        64'd0,        64'd5,        1,  "REM 5/0");
    add(0, REMU,   64'hFFFFFFFF, 64'd0,        64'hFFFFFFFF, 1,  "REMU max/0");
    add(0, DIV,    64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1,  "DIV overflow");
    add(0, REM,    64'h80000000, 64'hFFFFFFFF, 64'h0,        1,  "REM overflow");
    add(1, MUL,    64'd3,        64'd5,        64'd15,       9,  "U4 MUL 3*5");
    add(1, DIV,    64'hFFFFFF9C, 64'd7,        64'hFFFFFFF2, 9,  "U4 DIV -100/7");
    add(2, DIVU,   64'h100_0000_0000, 64'd3,   64'd366503875925, 33, "X64 DIVU 2^40/3");
    add(2, REMU,   64'h100_0000_0000, 64'd3,   64'd1,        33, "X64 REMU 2^40/3");
    add(2, MULH,   64'hFFFFFFFFFFFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFF, 33, "X64 MULH -1*2");
    add(2, DIV,    64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
                   64'h8000000000000000, 1, "X64 DIV overflow");

    // Reset state of every instance.
    #12;
    for (int i = 0; i < 3; i++) begin
      sel = i; #1;
      check($sformatf("reset result u%0d", i), obsRes, 64'd0);
      check($sformatf("reset busy u%0d", i), {63'd0, obsBusy}, 64'd0);
      check($sformatf("reset done u%0d", i), {63'd0, obsDone}, 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    foreach (vecs[i]) runVec(vecs[i]);

    // Back-to-back: second start issued in the done cycle of the first.
    pulseStart(0, DIVU, 64'd100, 64'd7);
    waitDone(lat, bc, bd);
    check("b2b first result", obsRes, 64'd14);
    pulseStart(0, REMU, 64'd100, 64'd7);
    check("b2b accepted", {63'd0, obsBusy}, 64'd1);
    waitDone(lat, bc, bd);
    check("b2b second latency", 64'(lat), 64'd33);
    check("b2b second result", obsRes, 64'd2);

    // Start while busy is ignored; the in-flight divide completes unchanged.
    pulseStart(0, DIVU, 64'd100, 64'd7);
    repeat (5) @(posedge clk);
    #1;
    fIn = MUL; aIn = 64'd3; bIn = 64'd3; startReq = 1'b1;
    @(posedge clk); #1;
    startReq = 1'b0;
    waitDone(lat, bc, bd);
    check("ignored start result", obsRes, 64'd14);
    check("ignored start latency", 64'(lat), 64'd27);

    // Kill mid-CALC keeps the previous result and suppresses done.
    pulseStart(0, MUL, 64'h1234, 64'd1);
    waitDone(lat, bc, bd);
    check("kill setup result", obsRes, 64'h1234);
    pulseStart(0, MUL, 64'd5, 64'd6);
    repeat (9) @(posedge clk);
    #1;
    killReq = 1'b1;
    @(posedge clk); #1;
    killReq = 1'b0;
    check("kill busy", {63'd0, obsBusy}, 64'd0);
    check("kill done", {63'd0, obsDone}, 64'd0);
    check("kill result held", obsRes, 64'h1234);
    doneSeen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (obsDone) doneSeen++;
    end
    check("kill no late done", 64'(doneSeen), 64'd0);

    // Kill in the FIN cycle of a special-case divide.
    pulseStart(0, DIVU, 64'd5, 64'd0);
    check("fin kill busy before", {63'd0, obsBusy}, 64'd1);
    killReq = 1'b1;
    @(posedge clk); #1;
    killReq = 1'b0;
    check("fin kill done", {63'd0, obsDone}, 64'd0);
    check("fin kill busy", {63'd0, obsBusy}, 64'd0);
    check("fin kill result held", obsRes, 64'h1234);

    // Kill together with start in IDLE drops the start.
    fIn = DIVU; aIn = 64'd5; bIn = 64'd0; startReq = 1'b1; killReq = 1'b1;
    @(posedge clk); #1;
    startReq = 1'b0; killReq = 1'b0;
    check("kill+start busy", {63'd0, obsBusy}, 64'd0);
    @(posedge clk); #1;
    check("kill+start done", {63'd0, obsDone}, 64'd0);
    check("kill+start result held", obsRes, 64'h1234);

    // Asynchronous reset between edges mid-CALC.
    pulseStart(0, MUL, 64'd7, 64'd9);
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async reset result", obsRes, 64'd0);
    check("async reset busy", {63'd0, obsBusy}, 64'd0);
    check("async reset done", {63'd0, obsDone}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    pulseStart(0, MUL, 64'd7, 64'd9);
    waitDone(lat, bc, bd);
    check("post reset result", obsRes, 64'd63);
    check("post reset latency", 64'(lat), 64'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
